// File: rtl/axi4_target_mem_bfm.sv
// AXI4 target BFM backed by a word-addressed memory; independent write/read FSMs, one burst in flight each.
// Define AXI4_TARGET_MEM_ERR_EN to enable SLVERR checking (range, size, wrap length, WLAST).
module axi4_target_mem_bfm #(
   parameter int AXI4_ADDRESS_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH    = 64,
   parameter int AXI4_ID_WIDTH      = 4,
   parameter int MEM_DEPTH_LOG2     = 10
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [AXI4_ADDRESS_WIDTH-1:0]   AWADDR,
   input  logic [AXI4_ID_WIDTH-1:0]        AWID,
   input  logic [7:0]                      AWLEN,
   input  logic [2:0]                      AWSIZE,
   input  logic [1:0]                      AWBURST,
   input  logic                            AWLOCK,
   input  logic [3:0]                      AWCACHE,
   input  logic [2:0]                      AWPROT,
   input  logic [3:0]                      AWQOS,
   input  logic [3:0]                      AWREGION,
   input  logic                            AWVALID,
   output logic                            AWREADY,
   input  logic [AXI4_DATA_WIDTH-1:0]      WDATA,
   input  logic [AXI4_DATA_WIDTH/8-1:0]    WSTRB,
   input  logic                            WLAST,
   input  logic                            WVALID,
   output logic                            WREADY,
   output logic [AXI4_ID_WIDTH-1:0]        BID,
   output logic [1:0]                      BRESP,
   output logic                            BVALID,
   input  logic                            BREADY,
   input  logic [AXI4_ADDRESS_WIDTH-1:0]   ARADDR,
   input  logic [AXI4_ID_WIDTH-1:0]        ARID,
   input  logic [7:0]                      ARLEN,
   input  logic [2:0]                      ARSIZE,
   input  logic [1:0]                      ARBURST,
   input  logic [3:0]                      ARCACHE,
   input  logic [2:0]                      ARPROT,
   input  logic [3:0]                      ARREGION,
   input  logic                            ARVALID,
   output logic                            ARREADY,
   output logic [AXI4_ID_WIDTH-1:0]        RID,
   output logic [AXI4_DATA_WIDTH-1:0]      RDATA,
   output logic [1:0]                      RRESP,
   output logic                            RLAST,
   output logic                            RVALID,
   input  logic                            RREADY
);
   localparam int AW    = AXI4_ADDRESS_WIDTH;
   localparam int DW    = AXI4_DATA_WIDTH;
   localparam int IDW   = AXI4_ID_WIDTH;
   localparam int NB    = DW / 8;
   localparam int OFF   = $clog2(NB);
   localparam int IW    = MEM_DEPTH_LOG2;
   localparam int DEPTH = 1 << IW;
   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   logic [DW-1:0] mem [DEPTH] = '{default: '0};

   function automatic logic [IW-1:0] word_idx(input logic [AW-1:0] a);
      return a[IW+OFF-1:OFF];
   endfunction

   // WRAP keeps the upper bits of the aligned window and lets only the low bits roll over.
   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
      logic [AW-1:0] step, win;
      step = AW'(1) << size;
      win  = (AW'(len) + AW'(1)) << size;
      case (burst)
         2'd0:    return a;
         2'd2:    return (a & ~(win - AW'(1))) | ((a + step) & (win - AW'(1)));
         default: return a + step;
      endcase
   endfunction

`ifdef AXI4_TARGET_MEM_ERR_EN
   function automatic logic addr_bad(input logic [AW-1:0] a, input logic [2:0] size);
      return ((a >> (IW + OFF)) != '0) || (int'(size) > OFF);
   endfunction

   function automatic logic wrap_bad(input logic [7:0] len, input logic [1:0] burst);
      return (burst == 2'd2) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15});
   endfunction
`endif

   // ---------------- write channel ----------------
   w_state_e        w_state_q, w_state_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [IDW-1:0]  wid_q, wid_d, bid_q, bid_d;
   logic [7:0]      wlen_q, wlen_d, wcnt_q, wcnt_d;
   logic [2:0]      wsize_q, wsize_d;
   logic [1:0]      wburst_q, wburst_d, bresp_q, bresp_d;
   logic            werr_q, werr_d;
   logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic            w_beat, w_drop, w_err;

   assign w_beat = wready_q && WVALID;

`ifdef AXI4_TARGET_MEM_ERR_EN
   assign w_drop = addr_bad(waddr_q, wsize_q);
   assign w_err  = w_drop || wrap_bad(wlen_q, wburst_q) || (WLAST != (wcnt_q == wlen_q));
`else
   assign w_drop = 1'b0;
   assign w_err  = 1'b0;
`endif

   always_comb begin
      w_state_d = w_state_q;
      waddr_d   = waddr_q;
      wid_d     = wid_q;
      bid_d     = bid_q;
      wlen_d    = wlen_q;
      wcnt_d    = wcnt_q;
      wsize_d   = wsize_q;
      wburst_d  = wburst_q;
      bresp_d   = bresp_q;
      werr_d    = werr_q;
      case (w_state_q)
         W_IDLE: if (AWVALID && awready_q) begin
            w_state_d = W_DATA;
            waddr_d   = AWADDR;
            wid_d     = AWID;
            wlen_d    = AWLEN;
            wsize_d   = AWSIZE;
            wburst_d  = AWBURST;
            wcnt_d    = '0;
            werr_d    = 1'b0;
         end
         W_DATA: if (w_beat) begin
            waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
            wcnt_d  = wcnt_q + 8'd1;
            werr_d  = werr_q | w_err;
            if (wcnt_q == wlen_q) begin
               w_state_d = W_RESP;
               bid_d     = wid_q;
               bresp_d   = (werr_q | w_err) ? RESP_SLVERR : RESP_OKAY;
            end
         end
         W_RESP: if (BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         w_state_q <= W_IDLE;
         waddr_q   <= '0;
         wid_q     <= '0;
         bid_q     <= '0;
         wlen_q    <= '0;
         wcnt_q    <= '0;
         wsize_q   <= '0;
         wburst_q  <= '0;
         bresp_q   <= RESP_OKAY;
         werr_q    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         waddr_q   <= waddr_d;
         wid_q     <= wid_d;
         bid_q     <= bid_d;
         wlen_q    <= wlen_d;
         wcnt_q    <= wcnt_d;
         wsize_q   <= wsize_d;
         wburst_q  <= wburst_d;
         bresp_q   <= bresp_d;
         werr_q    <= werr_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
      end
   end

   // Memory is deliberately outside reset: an aborted burst leaves its written beats in place.
   always_ff @(posedge clock) begin
      if (w_beat && !w_drop) begin
         for (int b = 0; b < NB; b++) begin
            if (WSTRB[b]) mem[word_idx(waddr_q)][8*b +: 8] <= WDATA[8*b +: 8];
         end
      end
   end

   // ---------------- read channel ----------------
   r_state_e        r_state_q, r_state_d;
   logic [AW-1:0]   raddr_q, raddr_d;
   logic [IDW-1:0]  rid_q, rid_d;
   logic [7:0]      rlen_q, rlen_d, rcnt_q, rcnt_d;
   logic [2:0]      rsize_q, rsize_d;
   logic [1:0]      rburst_q, rburst_d, rresp_q, rresp_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            rlast_q, rlast_d, rvalid_q, rvalid_d, arready_q, arready_d;
   logic            ld_en;
   logic [AW-1:0]   ld_addr;
   logic [7:0]      ld_len;
   logic [2:0]      ld_size;
   logic [1:0]      ld_burst;

   // RDATA is captured from the pre-edge array, so a same-cycle write is not visible.
   always_comb begin
      r_state_d = r_state_q;
      raddr_d   = raddr_q;
      rid_d     = rid_q;
      rlen_d    = rlen_q;
      rcnt_d    = rcnt_q;
      rsize_d   = rsize_q;
      rburst_d  = rburst_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      rlast_d   = rlast_q;
      ld_en     = 1'b0;
      ld_addr   = raddr_q;
      ld_len    = rlen_q;
      ld_size   = rsize_q;
      ld_burst  = rburst_q;
      case (r_state_q)
         R_IDLE: if (ARVALID && arready_q) begin
            r_state_d = R_DATA;
            raddr_d   = ARADDR;
            rid_d     = ARID;
            rlen_d    = ARLEN;
            rsize_d   = ARSIZE;
            rburst_d  = ARBURST;
            rcnt_d    = '0;
            rlast_d   = (ARLEN == 8'd0);
            ld_en     = 1'b1;
            ld_addr   = ARADDR;
            ld_len    = ARLEN;
            ld_size   = ARSIZE;
            ld_burst  = ARBURST;
         end
         R_DATA: if (rvalid_q && RREADY) begin
            if (rlast_q) begin
               r_state_d = R_IDLE;
               rlast_d   = 1'b0;
            end else begin
               raddr_d = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
               rcnt_d  = rcnt_q + 8'd1;
               rlast_d = ((rcnt_q + 8'd1) == rlen_q);
               ld_en   = 1'b1;
               ld_addr = raddr_d;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (ld_en) begin
         rdata_d = mem[word_idx(ld_addr)];
         rresp_d = RESP_OKAY;
`ifdef AXI4_TARGET_MEM_ERR_EN
         if (addr_bad(ld_addr, ld_size) || wrap_bad(ld_len, ld_burst)) begin
            rdata_d = '0;
            rresp_d = RESP_SLVERR;
         end
`endif
      end
      rvalid_d  = (r_state_d == R_DATA);
      arready_d = (r_state_d == R_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state_q <= R_IDLE;
         raddr_q   <= '0;
         rid_q     <= '0;
         rlen_q    <= '0;
         rcnt_q    <= '0;
         rsize_q   <= '0;
         rburst_q  <= '0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         rlast_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         arready_q <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         raddr_q   <= raddr_d;
         rid_q     <= rid_d;
         rlen_q    <= rlen_d;
         rcnt_q    <= rcnt_d;
         rsize_q   <= rsize_d;
         rburst_q  <= rburst_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         rlast_q   <= rlast_d;
         rvalid_q  <= rvalid_d;
         arready_q <= arready_d;
      end
   end

   assign AWREADY = awready_q;
   assign WREADY  = wready_q;
   assign BVALID  = bvalid_q;
   assign BID     = bid_q;
   assign BRESP   = bresp_q;
   assign ARREADY = arready_q;
   assign RVALID  = rvalid_q;
   assign RID     = rid_q;
   assign RDATA   = rdata_q;
   assign RRESP   = rresp_q;
   assign RLAST   = rlast_q;

   // Sideband attributes are accepted but carry no meaning for a flat memory.
   logic unused_sideband;
   assign unused_sideband = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, WLAST,
                              ARCACHE, ARPROT, ARREGION};
endmodule
